// File: rtl/mxn_pkg.sv
// Shared constants and helpers for the mxn_arb N-to-1 round-robin arbiter.
package mxn_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N     = 4;

  // Index width for a value range of v; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    for (r = 0; (32'd1 << r) < v; r++) begin
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Low bit of channel k in a flattened bus of w-bit channels.
  function automatic int unsigned ch_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/mxn_rr_pick.sv
// Circular find-first: first set bit of v searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module mxn_rr_pick
  import mxn_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    v,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // One extra bit so ptr + offset never overflows before the wrap subtract.
  localparam logic [SELW:0] NV = (SELW+1)'(N);

  logic [SELW:0]   sum;
  logic [SELW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (SELW+1)'(i);
      if (sum >= NV) sum = sum - NV;
      cand = sum[SELW-1:0];
      if (!found && v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mxn_arb.sv
// N-to-1 round-robin arbiter with a registered output word.
// Optional MXN_FIXED_MODE_EN adds mode/sel ports for a fixed-channel override.
module mxn_arb
  import mxn_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned N     = DEF_N,
  localparam int unsigned SELW  = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   d_in,
  input  logic [N-1:0]         v_in,
  output logic [N-1:0]         r_in,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
`ifdef MXN_FIXED_MODE_EN
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
`endif
  output logic [SELW-1:0]      grant
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0]  ptr;
  logic             load_en;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic             win_found;
  logic [SELW-1:0]  win_idx;
  logic             ptr_hold;
  logic [WIDTH-1:0] win_data;

  assign load_en = !y_valid || y_ready;

  mxn_rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .v     (v_in),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

`ifdef MXN_FIXED_MODE_EN
  // Fixed mode serves only sel; an out-of-range sel means no winner.
  logic sel_ok;
  assign sel_ok = (32'(sel) < N);

  always_comb begin
    if (mode) begin
      win_found = sel_ok && v_in[sel];
      win_idx   = sel;
    end else begin
      win_found = rr_found;
      win_idx   = rr_idx;
    end
  end

  assign ptr_hold = mode;
`else
  assign win_found = rr_found;
  assign win_idx   = rr_idx;
  assign ptr_hold  = 1'b0;
`endif

  always_comb begin
    r_in = '0;
    if (!reset && load_en && win_found) r_in = N'(1) << win_idx;
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win_idx == SELW'(k)) win_data = d_in[ch_lo(k, WIDTH) +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      grant   <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (win_found) begin
        y       <= win_data;
        y_valid <= 1'b1;
        grant   <= win_idx;
        if (!ptr_hold) ptr <= (win_idx == LAST) ? '0 : win_idx + SELW'(1);
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mxn_arb.sv
// Self-checking bench for mxn_arb: directed vector table, hand sequences, random vs reference model.
module tb_mxn_arb;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;
  localparam logic [N*W-1:0] DSET = 32'h4433_2211;

  logic             clk = 1'b0;
  logic             reset;
  logic [N*W-1:0]   d_in;
  logic [N-1:0]     v_in;
  logic [N-1:0]     r_in;
  logic [W-1:0]     y;
  logic             y_valid;
  logic             y_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [SELW-1:0]  grant;

  always #5 clk = ~clk;

  mxn_arb #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_in    (d_in),
    .v_in    (v_in),
    .r_in    (r_in),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
`ifdef MXN_FIXED_MODE_EN
    .mode    (mode),
    .sel     (sel),
`endif
    .grant   (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  int         m_ptr = 0;
  int         m_grant = 0;
  logic [W-1:0] m_y = '0;
  logic       m_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Winner from the rules: lowest active index at or above ptr, else lowest active overall.
  function automatic int model_win(input logic [N-1:0] v, input logic md, input logic [SELW-1:0] s, input int p);
    if (md) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = p; k < N; k++) if (v[k]) return k;
    for (int k = 0; k < p; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy,
                      input logic rst, input logic md, input logic [SELW-1:0] s,
                      output logic [N-1:0] r_seen);
    int w;
    logic ld;
    logic [N-1:0] exp_r;
    @(negedge clk);
    v_in = v; d_in = d; y_ready = rdy; reset = rst; mode = md; sel = s;
    #1;
`ifndef MXN_FIXED_MODE_EN
    md = 1'b0;
`endif
    w  = model_win(v, md, s, m_ptr);
    ld = !m_vld || rdy;
    exp_r = (!rst && ld && w >= 0) ? N'(1) << w : '0;
    r_seen = r_in;
    check("r_in", 32'(r_in), 32'(exp_r));
    @(posedge clk);
    #1;
    if (rst) begin
      m_y = '0; m_vld = 1'b0; m_grant = 0; m_ptr = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_y = d[w*W +: W]; m_vld = 1'b1; m_grant = w;
        if (!md) m_ptr = (w + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
    check("y", 32'(y), 32'(m_y));
    check("y_valid", 32'(y_valid), 32'(m_vld));
    check("grant", 32'(grant), m_grant);
  endtask

  typedef struct {
    logic [N-1:0]    v;
    logic            rdy;
    logic [N-1:0]    r;
    logic [SELW-1:0] g;
    logic [W-1:0]    yv;
    logic            vld;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [N-1:0] rs;
    reset = 1'b1; v_in = '0; d_in = '0; y_ready = 1'b0; mode = 1'b0; sel = '0;

    step('0, DSET, 1'b1, 1'b1, 1'b0, '0, rs);
    step('0, DSET, 1'b1, 1'b1, 1'b0, '0, rs);

    // Idle, full rotation, single channel, stall, resume, drain, restart from ptr 0
    for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 2'd0, 8'h11, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 2'd1, 8'h22, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 2'd2, 8'h33, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 2'd3, 8'h44, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 2'd0, 8'h11, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'b0100, 1'b1, 4'b0100, 2'd2, 8'h33, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'b1111, 1'b0, 4'b0000, 2'd2, 8'h33, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 2'd3, 8'h44, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd3, 8'h44, 1'b0});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 2'd0, 8'h11, 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].v, DSET, tbl[i].rdy, 1'b0, 1'b0, '0, rs);
      check($sformatf("vec%0d_r", i), 32'(rs), 32'(tbl[i].r));
      check($sformatf("vec%0d_g", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].yv));
      check($sformatf("vec%0d_vld", i), 32'(y_valid), 32'(tbl[i].vld));
    end

    // Wrap from 3 to 0: ptr is 1 here, so serve 2 first to land ptr on 3
    step(4'b0100, DSET, 1'b1, 1'b0, 1'b0, '0, rs);
    step(4'b1001, DSET, 1'b1, 1'b0, 1'b0, '0, rs);
    check("wrap_g3", 32'(grant), 32'd3);
    step(4'b1001, DSET, 1'b1, 1'b0, 1'b0, '0, rs);
    check("wrap_g0", 32'(grant), 32'd0);

    // Reset with ptr at 3 and a word pending: word discarded, search restarts at 0
    step(4'b0100, DSET, 1'b1, 1'b0, 1'b0, '0, rs);
    step(4'b1001, DSET, 1'b0, 1'b1, 1'b0, '0, rs);
    check("rst_r", 32'(rs), 32'd0);
    check("rst_vld", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    step(4'b1001, DSET, 1'b1, 1'b0, 1'b0, '0, rs);
    check("post_rst_g", 32'(grant), 32'd0);
    check("post_rst_y", 32'(y), 32'h11);

`ifdef MXN_FIXED_MODE_EN
    // ptr is 1 now; fixed sel=1 repeatedly must not advance it
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, DSET, 1'b1, 1'b0, 1'b1, 2'd1, rs);
      check("fix_g", 32'(grant), 32'd1);
    end
    step(4'b1101, DSET, 1'b1, 1'b0, 1'b1, 2'd1, rs);
    check("fix_drop_vld", 32'(y_valid), 32'd0);
    step(4'b1111, DSET, 1'b1, 1'b0, 1'b0, 2'd1, rs);
    check("fix_ptr_held", 32'(grant), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      logic md;
      md = 1'b0;
`ifdef MXN_FIXED_MODE_EN
      md = ($urandom_range(0, 3) == 0);
`endif
      step(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), md, SELW'($urandom), rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mxn_arb.md
MXN_ARB -- requirements
Module: mxn_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel (>=1).
REQ-002 SHALL have parameter N, default 4: channel count (>=2); localparam SELW = clog2(N), minimum 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port d_in  input  N*WIDTH: channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port v_in  input  N: per-channel valid.
REQ-007 SHALL have port r_in  output  N: per-channel ready, combinational, one-hot or zero.
REQ-008 SHALL have port y  output  WIDTH: registered selected data.
REQ-009 SHALL have port y_valid  output  1: y holds a valid word.
REQ-010 SHALL have port y_ready  input  1: downstream accepts y this cycle.
REQ-011 SHALL have port grant  output  SELW: channel index of the word currently in y.

Function
REQ-012 SHALL define load_en = !y_valid || y_ready; a transfer on channel k occurs when v_in[k] && r_in[k].
REQ-013 SHALL assert r_in[k] only when load_en is high and k is the winner; all other r_in bits 0.
REQ-014 Round-robin winner SHALL be the first k with v_in[k]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-015 On transfer from k: y<=d_in[k], y_valid<=1, grant<=k, ptr<=(k+1) mod N, all at the next edge; latency 1 cycle.
REQ-016 With load_en high and no v_in set: y_valid<=0; y, grant, ptr hold.
REQ-017 With load_en low (y_valid=1, y_ready=0): y, y_valid, grant, ptr SHALL hold; r_in=0.
REQ-018 Sustained throughput SHALL be one word per cycle while y_ready=1 and any v_in is set.
REQ-019 A single active channel SHALL be served every cycle; N active channels SHALL be served in index order, each once per N transfers.
REQ-020 ptr wrap SHALL occur from N-1 to 0; no value >= N SHALL be stored in ptr or grant.
REQ-021 r_in SHALL NOT depend on d_in; it MAY depend on y_ready combinationally.

Reset
REQ-022 While reset=1 at an edge: y=0, y_valid=0, grant=0, ptr=0 after that edge.
REQ-023 r_in SHALL be forced to 0 while reset=1; no transfer is counted during reset.
REQ-024 Reset mid-stream SHALL discard the word in y; the first post-reset winner is searched from channel 0.

Configuration
REQ-025 Macro MXN_FIXED_MODE_EN SHALL add ports mode (input, 1) and sel (input, SELW).
REQ-026 With macro defined and mode=1: winner SHALL be channel sel only if sel<N and v_in[sel]=1, otherwise none; ptr holds.
REQ-027 With macro defined and mode=0, or macro undefined: round-robin per REQ-014..REQ-015; without the macro, mode and sel ports SHALL NOT exist.
REQ-028 A change of mode or sel SHALL affect arbitration in the same cycle; a word already in y is unaffected.

Structure
REQ-029 Package mxn_pkg SHALL hold the clog2 function, the default WIDTH/N constants, and the channel-slice index helper.
REQ-030 Combinational sub-module mxn_rr_pick (inputs v, ptr; outputs found, idx) SHALL implement the circular find-first.
REQ-031 Output register, ptr, and the fixed-mode override SHALL reside in mxn_arb.

Verification
REQ-032 Reset, then N=4, WIDTH=8, v_in=0000 -> y=0, y_valid=0, grant=0, r_in=0000 for 5 cycles.
REQ-033 v_in=1111, d_in={8'h44,8'h33,8'h22,8'h11}, y_ready=1 -> grant 0,1,2,3,0 on consecutive cycles; y 11,22,33,44,11.
REQ-034 v_in=0100 only, y_ready=1 -> grant=2 every cycle; r_in=0100 every cycle.
REQ-035 y_valid=1, y_ready=0 for 3 cycles with v_in=1111 -> y, grant, ptr frozen; r_in=0000; resume on y_ready=1.
REQ-036 ptr=3, v_in=1001 -> winner 3, then 0 (wrap); reset asserted between -> next winner 0 and y_valid=0.
REQ-037 MXN_FIXED_MODE_EN, mode=1, sel=1, v_in=1111 -> grant=1 every cycle, ptr unchanged; v_in[1]=0 -> y_valid drops to 0.
